uart_tx_arbiter: RTL and testbench

//  Shares one uartTx instance between NUM_REQ byte producers (CSR port, debug console, DMA, ...).

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req searching upward from ptr+1,
// wrapping. Reusable by any round-robin arbiter.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uartTx between NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to let a requester hold the grant across bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = uart_pkg::DATA_BITS,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         arb_busy
);

    import uart_pkg::*;

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef UART_ARB_LOCK_EN
    logic             lock_q;
    logic [IDX_W-1:0] lock_id;

    // While locked only the holder may win; others wait even if valid.
    assign pick_req = lock_q
        ? (req_valid & (NUM_REQ'(1) << lock_id))
        : req_valid;
`else
    logic lock_unused;

    assign lock_unused = ^req_lock;
    assign pick_req    = req_valid;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign arb_busy  = (state != IDLE);
    assign req_ready = (state == IDLE && rst) ? pick_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
            lock_q   <= 1'b0;
            lock_id  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        tx_data  <= req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
                        grant_id <= pick_idx;
                        rr_ptr   <= pick_idx;
                        tx_start <= 1'b1;
                        state    <= START;
`ifdef UART_ARB_LOCK_EN
                        lock_q   <= req_lock[pick_idx];
                        lock_id  <= pick_idx;
`endif
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uartTx busy model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'b0;
    logic [3:0]  req_lock = 4'b0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_busy;

    int total = 0;
    int bad = 0;

    int m_last = 3;
    bit m_lq = 1'b0;
    int m_lid = 0;

    logic [7:0] dat [4];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    function automatic int model_pick(input logic [3:0] v);
        logic [3:0] e;
        e = v;
`ifdef UART_ARB_LOCK_EN
        if (m_lq) e = v & (4'b0001 << m_lid);
`endif
        for (int k = 1; k <= 4; k++) begin
            if (e[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_accept(input int w);
        m_last = w;
`ifdef UART_ARB_LOCK_EN
        if (req_lock[w]) begin
            m_lq = 1'b1;
            m_lid = w;
        end else begin
            m_lq = 1'b0;
        end
`endif
    endtask

    task automatic load_data();
        req_data = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    // Waits for an accept, then plays the uartTx side of one frame.
    task automatic run_frame(
        input  logic [3:0] after_v,
        output int         idx,
        output logic [7:0] d,
        output logic [3:0] rdy,
        output logic [3:0] vld,
        output bit         idle_ok,
        output bit         proto_ok,
        output bit         tmo
    );
        int dly;
        int len;
        tmo = 1'b1;
        idx = -1;
        d = 8'h00;
        rdy = 4'b0;
        vld = 4'b0;
        idle_ok = 1'b0;
        proto_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != 4'b0) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (tmo) return;
        rdy = req_ready;
        vld = req_valid;
        idle_ok = (arb_busy === 1'b0);
        for (int i = 0; i < 4; i++) if (rdy[i]) idx = i;
        @(negedge clk);
        d = tx_data;
        if (tx_start !== 1'b1 || req_ready !== 4'b0 || arb_busy !== 1'b1 ||
            grant_id !== idx[1:0]) proto_ok = 1'b0;
        req_valid = after_v;
        dly = $urandom_range(0, 2);
        len = $urandom_range(2, 6);
        if (dly == 0) tx_busy = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || req_ready !== 4'b0) proto_ok = 1'b0;
        end
        tx_busy = 1'b1;
        repeat (len) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || req_ready !== 4'b0 || tx_data !== d ||
                arb_busy !== 1'b1) proto_ok = 1'b0;
        end
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (tx_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_tx_start got=%b want=0", tx_start);
        end
        total++;
        if (req_ready !== 4'b0) begin
            bad++;
            $display("FAIL reset_req_ready got=%b want=0000", req_ready);
        end
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data got=%h want=00", tx_data);
        end
        total++;
        if (grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_grant_id got=%0d want=0", grant_id);
        end
        total++;
        if (arb_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_arb_busy got=%b want=0", arb_busy);
        end
        req_valid = 4'b0;
        rst = 1'b1;
        m_last = 3;
        m_lq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int idx;
        int exp;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] vld;
        bit iok;
        bit pok;
        bit tmo;
        dat[0] = 8'h00;
        dat[1] = 8'hA5;
        dat[2] = 8'h00;
        dat[3] = 8'h00;
        load_data();
        req_valid = 4'b0010;
        exp = model_pick(req_valid);
        run_frame(4'b0000, idx, d, rdy, vld, iok, pok, tmo);
        model_accept(exp);
        total++;
        if (tmo || idx !== exp) begin
            bad++;
            $display("FAIL single_grant got=%0d want=%0d", idx, exp);
        end
        total++;
        if (d !== 8'hA5) begin
            bad++;
            $display("FAIL single_data got=%h want=a5", d);
        end
        total++;
        if (!pok || !iok || rdy !== 4'b0010) begin
            bad++;
            $display("FAIL single_proto got=%b want=0010 ok=%0d", rdy, pok);
        end
        repeat (6) begin
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0 || tx_start !== 1'b0) begin
                bad++;
                $display("FAIL single_quiet got=%b want=0000", req_ready);
            end
        end
    endtask

    task automatic test_all_valid();
        int idx;
        int exp;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] vld;
        bit iok;
        bit pok;
        bit tmo;
        for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
        load_data();
        req_valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            exp = model_pick(req_valid);
            run_frame(4'b1111, idx, d, rdy, vld, iok, pok, tmo);
            model_accept(exp);
            total++;
            if (tmo || idx !== exp) begin
                bad++;
                $display("FAIL rr_grant got=%0d want=%0d", idx, exp);
            end
            total++;
            if (d !== 8'h10 + 8'(exp)) begin
                bad++;
                $display("FAIL rr_data got=%h want=%h", d, 8'h10 + 8'(exp));
            end
            total++;
            if (!pok || !iok || !$onehot(rdy)) begin
                bad++;
                $display("FAIL rr_proto got=%b want=onehot ok=%0d", rdy, pok);
            end
        end
        req_valid = 4'b0;
    endtask

    task automatic test_late_req();
        int idx;
        int exp;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] vld;
        bit iok;
        bit pok;
        bit tmo;
        dat[0] = 8'h3C;
        dat[2] = 8'hC3;
        load_data();
        req_valid = 4'b0100;
        exp = model_pick(req_valid);
        run_frame(4'b0101, idx, d, rdy, vld, iok, pok, tmo);
        model_accept(exp);
        total++;
        if (tmo || idx !== 2 || !pok) begin
            bad++;
            $display("FAIL late_first got=%0d want=2", idx);
        end
        exp = model_pick(req_valid);
        run_frame(4'b0000, idx, d, rdy, vld, iok, pok, tmo);
        model_accept(exp);
        total++;
        if (tmo || idx !== 0 || d !== 8'h3C || !pok || !iok) begin
            bad++;
            $display("FAIL late_second got=%0d want=0", idx);
        end
    endtask

    task automatic test_reset_mid_frame();
        int idx;
        int exp;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] vld;
        bit iok;
        bit pok;
        bit tmo;
        bit seen;
        seen = 1'b0;
        dat[1] = 8'h5A;
        dat[2] = 8'h77;
        load_data();
        req_valid = 4'b0110;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != 4'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_busy = 1'b1;
        req_valid = 4'b0;
        repeat (3) @(negedge clk);
        total++;
        if (!seen || arb_busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy got=%b want=1", arb_busy);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tx_busy = 1'b0;
        m_last = 3;
        m_lq = 1'b0;
        #1;
        total++;
        if (arb_busy !== 1'b0 || tx_start !== 1'b0 ||
            tx_data !== 8'h00 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL midrst_state got=%b%b%h%0d want=00000",
                     arb_busy, tx_start, tx_data, grant_id);
        end
        req_valid = 4'b0110;
        exp = model_pick(req_valid);
        run_frame(4'b0000, idx, d, rdy, vld, iok, pok, tmo);
        model_accept(exp);
        total++;
        if (tmo || idx !== 1 || d !== 8'h5A || !pok) begin
            bad++;
            $display("FAIL midrst_next got=%0d want=1", idx);
        end
    endtask

    task automatic test_lock();
        int idx;
        int exp;
        int n1;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] vld;
        bit iok;
        bit pok;
        bit tmo;
        n1 = 0;
        dat[1] = 8'hB1;
        dat[3] = 8'hB3;
        load_data();
        req_valid = 4'b1010;
        for (int f = 0; f < 6; f++) begin
            req_lock = (n1 < 2) ? 4'b0010 : 4'b0000;
            exp = model_pick(req_valid);
            run_frame(4'b1010, idx, d, rdy, vld, iok, pok, tmo);
            model_accept(exp);
            if (exp == 1) n1++;
            total++;
            if (tmo || idx !== exp || d !== dat[exp] || !pok || !iok) begin
                bad++;
                $display("FAIL lock_seq got=%0d want=%0d", idx, exp);
            end
        end
        req_lock = 4'b0;
        req_valid = 4'b0;
    endtask

    task automatic test_back_to_back();
        int idx;
        int exp;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [3:0] vld;
        bit iok;
        bit pok;
        bit tmo;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            load_data();
            req_valid = 4'($urandom_range(1, 15));
            exp = model_pick(req_valid);
            run_frame(4'($urandom), idx, d, rdy, vld, iok, pok, tmo);
            model_accept(exp);
            total++;
            if (tmo || idx !== exp) begin
                bad++;
                $display("FAIL rand_grant got=%0d want=%0d", idx, exp);
            end
            total++;
            if (d !== dat[exp]) begin
                bad++;
                $display("FAIL rand_data got=%h want=%h", d, dat[exp]);
            end
            total++;
            if (!pok || !iok || !$onehot(rdy) || (rdy & ~vld) != 4'b0) begin
                bad++;
                $display("FAIL rand_proto got=%b want=onehot of %b", rdy, vld);
            end
        end
        req_valid = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_late_req();
        test_reset_mid_frame();
        test_lock();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
